// File: rtl/iob_2p_assim_mem_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : iob_2p_assim_mem_rd_ctrl_if
//  Description : Control, memory-read and output-stream signals of the
//                streaming memory read controller.
//                slave  = controller view, master = environment view.
//  Revision    : 1.0  initial release
// ============================================================================
interface iob_2p_assim_mem_rd_ctrl_if #(
    parameter int R_DATA_W = 8,
    parameter int R_ADDR_W = 15,
    parameter int LEN_W    = 16
);
    // Transfer control
    logic                start;
    logic [R_ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]    len;
    logic                busy;
    logic                done;
    // Memory read port
    logic                r_en;
    logic [R_ADDR_W-1:0] r_addr;
    logic [R_DATA_W-1:0] r_data;
    // Output stream
    logic [R_DATA_W-1:0] m_data;
    logic                m_valid;
    logic                m_ready;

    modport slave (
        input  start, base_addr, len, r_data, m_ready,
        output busy, done, r_en, r_addr, m_data, m_valid
    );

    modport master (
        output start, base_addr, len, r_data, m_ready,
        input  busy, done, r_en, r_addr, m_data, m_valid
    );
endinterface
`default_nettype wire

// File: rtl/iob_2p_assim_mem_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : iob_2p_assim_mem_rd_ctrl
//  Description : Reads len consecutive words from a 1-cycle-latency memory
//                starting at base_addr and streams them out through a
//                2-entry FIFO with valid/ready flow control.
//  Revision    : 1.0  initial release
// ============================================================================
module iob_2p_assim_mem_rd_ctrl #(
    parameter int R_DATA_W = 8,
    parameter int R_ADDR_W = 15,
    parameter int LEN_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    iob_2p_assim_mem_rd_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_issued;
    logic [R_ADDR_W-1:0] r_next_addr;
    logic [R_ADDR_W-1:0] r_last_addr;
    logic                r_busy;
    logic                r_done;

    logic                r_inflight;
    logic [1:0]          r_count;
    logic [R_DATA_W-1:0] r_head;
    logic [R_DATA_W-1:0] r_tail;
    logic                r_m_valid;

    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_level;
    logic                w_r_en;
    logic                w_last_issue;
    logic                w_last_beat;
    logic [1:0]          w_count_nxt;

    // Beat leaves the FIFO this cycle; memory data arrives for last cycle's read
    assign w_pop  = r_m_valid & bus.m_ready;
    assign w_push = r_inflight;

    // Slots that will be occupied after this cycle's pop; a pop frees room
    // in the same cycle, which is what sustains one beat per cycle.
    assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Read enable has to see the current pop, so it cannot be registered.
    assign w_r_en       = (r_state == RUN) && (r_issued < r_len) && (w_level < 3'd2);
    assign w_last_issue = w_r_en && ((r_issued + LEN_W'(1)) == r_len);

    // In DRAIN every read is issued; the last beat is the one emptying the FIFO
    assign w_last_beat  = (r_state == DRAIN) && w_pop && (r_count == 2'd1) && !r_inflight;

    assign w_count_nxt  = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Transfer FSM: accepts start, issues reads, tracks addresses, signals done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_next_addr <= '0;
            r_last_addr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_len       <= bus.len;
                        r_issued    <= '0;
                        r_next_addr <= bus.base_addr;
                        if (bus.len != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_r_en) begin
                        r_issued    <= r_issued + LEN_W'(1);
                        r_last_addr <= r_next_addr;
                        r_next_addr <= r_next_addr + R_ADDR_W'(1);
                        if (w_last_issue) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_beat) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output FIFO; r_head drives m_data and only moves on a pop
    // or when the FIFO is empty, so m_data is stable while a beat waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            r_inflight <= w_r_en;
            r_count    <= w_count_nxt;
            r_m_valid  <= (w_count_nxt != 2'd0);
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head <= r_tail;
                    if (w_push) begin
                        r_tail <= bus.r_data;
                    end
                end else if (w_push) begin
                    r_head <= bus.r_data;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= bus.r_data;
                end else begin
                    r_tail <= bus.r_data;
                end
            end
        end
    end

    // Address holds the last issued read whenever no read is requested
    assign bus.r_en    = w_r_en;
    assign bus.r_addr  = w_r_en ? r_next_addr : r_last_addr;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.m_data  = r_head;
    assign bus.m_valid = r_m_valid;

endmodule
`default_nettype wire

// File: doc/iob_2p_assim_mem_rd_ctrl.md
IOB_2P_ASSIM_MEM_RD_CTRL -- requirements
Module: iob_2p_assim_mem_rd_ctrl

Interface
REQ-001 SHALL have parameter R_DATA_W, default 8, width of the memory read port and output stream data.
REQ-002 SHALL have parameter R_ADDR_W, default 15, width of the memory read address.
REQ-003 SHALL have parameter LEN_W, default 16, width of the transfer length.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr  input  R_ADDR_W  first read address, sampled with start.
REQ-008 SHALL have port len  input  LEN_W  number of words to read, sampled with start.
REQ-009 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-011 SHALL have port r_en  output  1  memory read enable.
REQ-012 SHALL have port r_addr  output  R_ADDR_W  memory read address.
REQ-013 SHALL have port r_data  input  R_DATA_W  memory read data, valid the cycle after r_en.
REQ-014 SHALL have port m_data  output  R_DATA_W  output stream data.
REQ-015 SHALL have port m_valid  output  1  output stream valid.
REQ-016 SHALL have port m_ready  input  1  output stream ready.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-018 IDLE: start=1 SHALL latch base_addr/len and go to RUN (len>0) or pulse done next cycle and stay IDLE (len=0, no r_en issued).
REQ-019 start SHALL be ignored while busy=1.
REQ-020 RUN: r_en SHALL be asserted while issued count < len and (buffer occupancy + reads in flight - pop this cycle) < 2.
REQ-021 r_addr SHALL equal base_addr on first read, then increment by 1 per read, wrapping modulo 2^R_ADDR_W.
REQ-022 r_addr SHALL hold its last value when r_en=0.
REQ-023 Memory read latency SHALL be exactly one cycle; r_data SHALL be captured into a 2-entry FIFO the cycle after each r_en.
REQ-024 m_valid SHALL be high whenever the FIFO is non-empty; m_data SHALL be the FIFO head; beat transfers when m_valid and m_ready are both high.
REQ-025 m_data/m_valid SHALL be registered outputs; once m_valid is high, m_data SHALL not change until the beat transfers.
REQ-026 Words SHALL be delivered in ascending address order, none dropped or duplicated, under any m_ready pattern.
REQ-027 RUN to DRAIN when last read issued; DRAIN to IDLE when the last beat transfers.
REQ-028 done SHALL pulse one cycle, the cycle after the last beat transfers; busy SHALL drop in that same cycle.
REQ-029 busy SHALL be high from the cycle after start is accepted until done.
REQ-030 First m_valid SHALL assert no later than 3 cycles after the start-sampling edge.
REQ-031 With m_ready held high, throughput SHALL be one beat per cycle after the first beat.
REQ-032 Transfer counters SHALL be LEN_W bits; len up to 2^LEN_W-1 SHALL be supported.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, busy=0, done=0, r_en=0, r_addr=0, m_valid=0, m_data=0, FIFO empty, counters 0.
REQ-034 Reset mid-transfer SHALL abandon the transfer; the first accepted start after release SHALL behave as from power-up.

Verification
REQ-035 Memory preloaded bytes 32..47 at addresses 0..15; start base=0 len=16, m_ready=1 -> m_data 32..47 on 16 consecutive cycles, then done pulse, busy low.
REQ-036 Same load, m_ready toggled 1,0,1,0... -> same 16 values in order; r_en never asserted with occupancy+in-flight at 2; m_data stable while m_ready=0.
REQ-037 base=2^R_ADDR_W-2, len=4 -> r_addr sequence 32766, 32767, 0, 1; four beats out.
REQ-038 start with len=0 -> no r_en, no m_valid, done pulse one cycle later, busy stays 0.
REQ-039 start asserted again while busy during a len=8 transfer -> ignored; exactly 8 beats, one done.
REQ-040 rst_n pulsed low after 5 of 16 beats -> all outputs zero immediately; subsequent start base=0 len=4 -> beats 32..35 and done.
